// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and defaults for the pixel point-operation engine
// Purpose: mode enum, default parameter constants, packed per-frame config struct
//          and the raw-mode decode helper.
package pixel_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CHANNELS  = 3;
    localparam int DEF_GAIN_FRAC = 4;

    typedef enum logic [2:0] {
        MODE_ADD  = 3'b000,
        MODE_SUB  = 3'b001,
        MODE_THR  = 3'b010,
        MODE_INV  = 3'b011,
        MODE_GAIN = 3'b100,
        MODE_PASS = 3'b101
    } mode_e;

    // Active frame configuration; sample fields are sized at the default DATA_W.
    typedef struct packed {
        mode_e                   mode;
        logic [DEF_DATA_W-1:0]   value;
        logic [DEF_DATA_W-1:0]   threshold;
    } pix_cfg_t;

    // Codes 101..111 all mean pass-through.
    function automatic mode_e decode_mode(input logic [2:0] raw);
        return (raw > 3'd4) ? MODE_PASS : mode_e'(raw);
    endfunction

endpackage

// File: rtl/pixel_point_alu.sv
// rtl/pixel_point_alu.sv - one-channel two-stage point-operation datapath
// Purpose: stage 1 registers operands and raw sum/difference/product, stage 2
//          saturates and selects the result.
// Ports: clk, rst (sync active-high), i_en (advance both stages), i_x sample,
//        i_mode/i_value/i_threshold effective config, o_data result,
//        o_clip (only with PIXOP_CLIP_COUNT_EN) result saturated at 0/MAX by add/sub/gain.
module pixel_point_alu
    import pixel_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_x,
    input  mode_e             i_mode,
    input  logic [DATA_W-1:0] i_value,
    input  logic [DATA_W-1:0] i_threshold,
`ifdef PIXOP_CLIP_COUNT_EN
    output logic              o_clip,
`endif
    output logic [DATA_W-1:0] o_data
);

    localparam int                PW  = 2 * DATA_W;
    localparam logic [DATA_W-1:0] MAX = '1;

    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_thr;
    mode_e             r_mode;
    logic [DATA_W:0]   r_sum;
    logic [DATA_W:0]   r_diff;
    logic [PW-1:0]     r_prod;
    logic [DATA_W-1:0] r_data;

    logic [PW-1:0]     w_prod_sh;
    logic [DATA_W-1:0] w_res;
    logic              w_sat_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_thr  <= '0;
            r_mode <= MODE_PASS;
            r_sum  <= '0;
            r_diff <= '0;
            r_prod <= '0;
        end else if (i_en) begin
            r_x    <= i_x;
            r_thr  <= i_threshold;
            r_mode <= i_mode;
            r_sum  <= {1'b0, i_x} + {1'b0, i_value};
            // Top bit of the widened difference is the borrow.
            r_diff <= {1'b0, i_x} - {1'b0, i_value};
            r_prod <= PW'(i_x) * PW'(i_value);
        end
    end

    assign w_prod_sh = r_prod >> GAIN_FRAC;

    always_comb begin
        w_res    = r_x;
        w_sat_op = 1'b0;
        case (r_mode)
            MODE_ADD: begin
                w_res    = r_sum[DATA_W] ? MAX : r_sum[DATA_W-1:0];
                w_sat_op = 1'b1;
            end
            MODE_SUB: begin
                w_res    = r_diff[DATA_W] ? '0 : r_diff[DATA_W-1:0];
                w_sat_op = 1'b1;
            end
            MODE_THR:  w_res = (r_x > r_thr) ? MAX : '0;
            MODE_INV:  w_res = MAX - r_x;
            MODE_GAIN: begin
                w_res    = (|w_prod_sh[PW-1:DATA_W]) ? MAX : w_prod_sh[DATA_W-1:0];
                w_sat_op = 1'b1;
            end
            default:   w_res = r_x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_res;
        end
    end

    assign o_data = r_data;

`ifdef PIXOP_CLIP_COUNT_EN
    logic r_clip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clip <= 1'b0;
        end else if (i_en) begin
            r_clip <= w_sat_op && ((w_res == '0) || (w_res == MAX));
        end
    end

    assign o_clip = r_clip;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat_op;
`endif

endmodule

// File: rtl/pixel_point_stream.sv
// rtl/pixel_point_stream.sv - streaming per-pixel point-operation engine (top)
// Purpose: valid/ready pixel stream through a 2-stage per-channel point-op pipeline
//          with per-frame config capture. Optional macro PIXOP_CLIP_COUNT_EN adds clip_count.
// Ports: clk, rst (sync active-high); cfg_mode/cfg_value/cfg_threshold config inputs;
//        s_valid/s_ready/s_sof/s_data input stream; m_valid/m_ready/m_sof/m_data output
//        stream; clip_count (macro only) saturated-sample count for the current frame.
module pixel_point_stream
    import pixel_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 cfg_mode,
    input  logic [DATA_W-1:0]          cfg_value,
    input  logic [DATA_W-1:0]          cfg_threshold,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_sof,
    input  logic [CHANNELS*DATA_W-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_sof,
`ifdef PIXOP_CLIP_COUNT_EN
    output logic [31:0]                clip_count,
`endif
    output logic [CHANNELS*DATA_W-1:0] m_data
);

    pix_cfg_t r_cfg;
    logic     r_cap_pending;
    logic     r_v1, r_sof1;
    logic     r_v2, r_sof2;

    pix_cfg_t w_cfg_in;
    pix_cfg_t w_cfg_eff;
    logic     w_pipe_en;
    logic     w_accept;
    logic     w_load;

    assign w_pipe_en = !r_v2 || m_ready;
    assign s_ready   = w_pipe_en;
    assign w_accept  = s_valid && w_pipe_en;
    assign w_load    = w_accept && (s_sof || r_cap_pending);

    always_comb begin
        w_cfg_in           = r_cfg;
        w_cfg_in.mode      = decode_mode(cfg_mode);
        w_cfg_in.value     = cfg_value;
        w_cfg_in.threshold = cfg_threshold;
    end

    // The capturing beat itself uses the fresh config, so bypass the register.
    assign w_cfg_eff = w_load ? w_cfg_in : r_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg.mode      <= MODE_PASS;
            r_cfg.value     <= '0;
            r_cfg.threshold <= '0;
            r_cap_pending   <= 1'b1;
        end else if (w_accept) begin
            if (w_load) begin
                r_cfg <= w_cfg_in;
            end
            r_cap_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
        end else if (w_pipe_en) begin
            r_v1   <= s_valid;
            r_sof1 <= s_valid && s_sof;
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
        end
    end

    assign m_valid = r_v2;
    assign m_sof   = r_sof2;

`ifdef PIXOP_CLIP_COUNT_EN
    logic [CHANNELS-1:0] w_clip;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pixel_point_alu #(
            .DATA_W    (DATA_W),
            .GAIN_FRAC (GAIN_FRAC)
        ) u_alu (
            .clk         (clk),
            .rst         (rst),
            .i_en        (w_pipe_en),
            .i_x         (s_data[g*DATA_W +: DATA_W]),
            .i_mode      (w_cfg_eff.mode),
            .i_value     (w_cfg_eff.value),
            .i_threshold (w_cfg_eff.threshold),
`ifdef PIXOP_CLIP_COUNT_EN
            .o_clip      (w_clip[g]),
`endif
            .o_data      (m_data[g*DATA_W +: DATA_W])
        );
    end

`ifdef PIXOP_CLIP_COUNT_EN
    localparam int CW = $clog2(CHANNELS + 1);

    logic [CW-1:0] w_clip_sum;
    logic [31:0]   r_clip_count;

    always_comb begin
        w_clip_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_clip_sum = w_clip_sum + CW'(w_clip[i]);
        end
    end

    // A frame-start beat restarts the count with its own clips.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clip_count <= '0;
        end else if (r_v2 && m_ready) begin
            if (r_sof2) begin
                r_clip_count <= 32'(w_clip_sum);
            end else begin
                r_clip_count <= r_clip_count + 32'(w_clip_sum);
            end
        end
    end

    assign clip_count = r_clip_count;
`endif

endmodule

// File: tb/tb_pixel_point_stream.sv
// tb/tb_pixel_point_stream.sv - directed self-checking bench for pixel_point_stream
module tb_pixel_point_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cfg_mode = 3'd0;
    logic [7:0]  cfg_value = 8'd0;
    logic [7:0]  cfg_threshold = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_sof = 1'b0;
    logic [23:0] s_data = 24'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_sof;
    logic [23:0] m_data;
`ifdef PIXOP_CLIP_COUNT_EN
    logic [31:0] clip_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_point_stream dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_mode      (cfg_mode),
        .cfg_value     (cfg_value),
        .cfg_threshold (cfg_threshold),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sof         (s_sof),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sof         (m_sof),
`ifdef PIXOP_CLIP_COUNT_EN
        .clip_count    (clip_count),
`endif
        .m_data        (m_data)
    );

    function automatic logic [23:0] pk(input logic [7:0] c2, input logic [7:0] c1, input logic [7:0] c0);
        return {c2, c1, c0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic sof, input logic [2:0] mode, input logic [7:0] val,
                            input logic [7:0] thr, input logic [23:0] d);
        s_valid       = 1'b1;
        s_sof         = sof;
        cfg_mode      = mode;
        cfg_value     = val;
        cfg_threshold = thr;
        s_data        = d;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_data !== 24'd0) begin bad++; $display("FAIL reset_m_data got=%h want=000000", m_data); end
        total++; if (m_sof !== 1'b0) begin bad++; $display("FAIL reset_m_sof got=%b want=0", m_sof); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd0) begin bad++; $display("FAIL reset_clip_count got=%0d want=0", clip_count); end
`endif
        m_ready = 1'b1;
    endtask

    task automatic test_add;
        set_beat(1'b1, 3'b000, 8'd100, 8'd0, pk(8'd200, 8'd155, 8'd10));
        tick;
        s_valid = 1'b0;
        tick;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", m_valid); end
        total++; if (m_sof !== 1'b1) begin bad++; $display("FAIL add_sof got=%b want=1", m_sof); end
        total++; if (m_data !== pk(8'd255, 8'd255, 8'd110)) begin bad++; $display("FAIL add_data got=%h want=%h", m_data, pk(8'd255, 8'd255, 8'd110)); end
        tick;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_no_dup got=%b want=0", m_valid); end
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd2) begin bad++; $display("FAIL add_clip_count got=%0d want=2", clip_count); end
`endif
    endtask

    task automatic test_sub_thr;
        set_beat(1'b1, 3'b001, 8'd50, 8'd0, pk(8'd30, 8'd50, 8'd51));
        tick;
        set_beat(1'b1, 3'b010, 8'd0, 8'd128, pk(8'd128, 8'd129, 8'd0));
        tick;
        s_valid = 1'b0;
        total++; if (m_data !== pk(8'd0, 8'd0, 8'd1) || m_valid !== 1'b1) begin bad++; $display("FAIL sub_data got=%h v=%b want=%h v=1", m_data, m_valid, pk(8'd0, 8'd0, 8'd1)); end
        tick;
        total++; if (m_data !== pk(8'd0, 8'd255, 8'd0) || m_valid !== 1'b1) begin bad++; $display("FAIL thr_data got=%h v=%b want=%h v=1", m_data, m_valid, pk(8'd0, 8'd255, 8'd0)); end
        total++; if (m_sof !== 1'b1) begin bad++; $display("FAIL thr_sof got=%b want=1", m_sof); end
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd2) begin bad++; $display("FAIL sub_clip_count got=%0d want=2", clip_count); end
`endif
        tick;
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd0) begin bad++; $display("FAIL thr_clip_count got=%0d want=0", clip_count); end
`endif
    endtask

    task automatic test_gain;
        set_beat(1'b1, 3'b100, 8'h18, 8'd0, pk(8'd100, 8'd170, 8'd0));
        tick;
        s_valid = 1'b0;
        tick;
        total++; if (m_data !== pk(8'd150, 8'd255, 8'd0) || m_valid !== 1'b1) begin bad++; $display("FAIL gain_data got=%h v=%b want=%h v=1", m_data, m_valid, pk(8'd150, 8'd255, 8'd0)); end
        tick;
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd2) begin bad++; $display("FAIL gain_clip_count got=%0d want=2", clip_count); end
`endif
    endtask

    task automatic test_midframe_cfg;
        set_beat(1'b1, 3'b011, 8'd0, 8'd0, pk(8'd10, 8'd10, 8'd10));
        tick;
        set_beat(1'b0, 3'b000, 8'd5, 8'd0, pk(8'd10, 8'd20, 8'd30));
        tick;
        total++; if (m_data !== pk(8'd245, 8'd245, 8'd245) || m_sof !== 1'b1) begin bad++; $display("FAIL inv_data got=%h sof=%b want=%h sof=1", m_data, m_sof, pk(8'd245, 8'd245, 8'd245)); end
        set_beat(1'b1, 3'b000, 8'd5, 8'd0, pk(8'd10, 8'd20, 8'd30));
        tick;
        s_valid = 1'b0;
        total++; if (m_data !== pk(8'd245, 8'd235, 8'd225) || m_sof !== 1'b0) begin bad++; $display("FAIL midframe_hold got=%h sof=%b want=%h sof=0", m_data, m_sof, pk(8'd245, 8'd235, 8'd225)); end
        tick;
        total++; if (m_data !== pk(8'd15, 8'd25, 8'd35) || m_sof !== 1'b1 || m_valid !== 1'b1) begin bad++; $display("FAIL next_frame_add got=%h sof=%b v=%b want=%h sof=1 v=1", m_data, m_sof, m_valid, pk(8'd15, 8'd25, 8'd35)); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp_q[8];
        logic [23:0] held_data;
        logic        held_sof;
        logic        was_stall;
        logic        acc, xfer;
        int          in_idx, out_idx, cyc;
        logic [3:0]  pat;
        pat       = 4'b1001;
        in_idx    = 0;
        out_idx   = 0;
        cyc       = 0;
        was_stall = 1'b0;
        held_data = '0;
        held_sof  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = pk(8'(3*i+3), 8'(3*i+2), 8'(3*i+1));
        end
        while (out_idx < 8 && cyc < 80) begin
            m_ready = pat[cyc % 4];
            if (in_idx < 8) begin
                set_beat(in_idx == 0, 3'b000, 8'd1, 8'd0, pk(8'(3*in_idx+2), 8'(3*in_idx+1), 8'(3*in_idx)));
            end else begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
            end
            #1;
            total++; if (s_ready !== (!m_valid || m_ready)) begin bad++; $display("FAIL bp_s_ready cyc=%0d got=%b want=%b", cyc, s_ready, !m_valid || m_ready); end
            if (was_stall) begin
                total++; if (m_valid !== 1'b1 || m_data !== held_data || m_sof !== held_sof) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%b/%b want=%h/%b/1", cyc, m_data, m_sof, m_valid, held_data, held_sof); end
            end
            acc  = s_valid && s_ready;
            xfer = m_valid && m_ready;
            if (xfer) begin
                total++; if (m_data !== exp_q[out_idx] || m_sof !== (out_idx == 0)) begin bad++; $display("FAIL bp_data idx=%0d got=%h sof=%b want=%h sof=%b", out_idx, m_data, m_sof, exp_q[out_idx], out_idx == 0); end
            end
            was_stall = m_valid && !m_ready;
            held_data = m_data;
            held_sof  = m_sof;
            @(posedge clk);
            #1;
            if (acc) in_idx++;
            if (xfer) out_idx++;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        total++; if (out_idx != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", out_idx); end
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_beat k=%0d got=%b want=0", k, m_valid); end
        end
    endtask

    task automatic test_reset_midframe;
        set_beat(1'b1, 3'b101, 8'd0, 8'd0, pk(8'd1, 8'd2, 8'd3));
        tick;
        set_beat(1'b0, 3'b101, 8'd0, 8'd0, pk(8'd4, 8'd5, 8'd6));
        tick;
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_inflight got=%b want=1", m_valid); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (m_valid !== 1'b0 || m_data !== 24'd0 || m_sof !== 1'b0) begin bad++; $display("FAIL rstmid_clear got=%h/%b/%b want=000000/0/0", m_data, m_sof, m_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_s_ready got=%b want=1", s_ready); end
`ifdef PIXOP_CLIP_COUNT_EN
        total++; if (clip_count !== 32'd0) begin bad++; $display("FAIL rstmid_clip_count got=%0d want=0", clip_count); end
`endif
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale k=%0d got=%b want=0", k, m_valid); end
        end
        set_beat(1'b0, 3'b011, 8'd0, 8'd0, pk(8'd20, 8'd20, 8'd20));
        tick;
        set_beat(1'b0, 3'b000, 8'd5, 8'd0, pk(8'd20, 8'd20, 8'd20));
        tick;
        s_valid = 1'b0;
        total++; if (m_data !== pk(8'd235, 8'd235, 8'd235) || m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_capture got=%h v=%b want=%h v=1", m_data, m_valid, pk(8'd235, 8'd235, 8'd235)); end
        tick;
        total++; if (m_data !== pk(8'd235, 8'd235, 8'd235) || m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_hold_cfg got=%h v=%b want=%h v=1", m_data, m_valid, pk(8'd235, 8'd235, 8'd235)); end
        tick;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_thr;
        test_gain;
        test_midframe_cfg;
        test_back_to_back;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
